// File: rtl/trunc_unit_scheduler.sv
// Purpose: shares one combinational 32-bit truncation unit between requesters A and B.
// Latency: result is registered at the edge ending the single ISSUE cycle after acceptance.
// Backpressure: R_Ready low holds the result and blocks new grants; requesters hold Valid until Ready.
//
// Ports:
//   Clk, Rst              clock (rising edge) and synchronous active-high reset
//   A_* / B_*             requester ports: Valid/Ready handshake, In1 data, In2 control word, Tag
//   Tr_In1/Tr_In2/Tr_En.. drive the shared truncation unit; Tr_Out is its combinational result
//   R_Valid/R_Ready       result handshake; R_Data/R_Src/R_Tag describe the result
//   Busy                  high whenever an operation is in flight
//
// Build option: define TRUNC_SCHED_FIXED_PRIO_EN for fixed priority (A always wins a
// conflict). Left undefined, conflicts are resolved round-robin.
module trunc_unit_scheduler #(
  parameter int W     = 32,
  parameter int TAG_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             A_Valid,
  output logic             A_Ready,
  input  logic [W-1:0]     A_In1,
  input  logic [W-1:0]     A_In2,
  input  logic [TAG_W-1:0] A_Tag,
  input  logic             B_Valid,
  output logic             B_Ready,
  input  logic [W-1:0]     B_In1,
  input  logic [W-1:0]     B_In2,
  input  logic [TAG_W-1:0] B_Tag,
  output logic [W-1:0]     Tr_In1,
  output logic [W-1:0]     Tr_In2,
  output logic             Tr_Enable,
  input  logic [W-1:0]     Tr_Out,
  output logic             R_Valid,
  input  logic             R_Ready,
  output logic [W-1:0]     R_Data,
  output logic             R_Src,
  output logic [TAG_W-1:0] R_Tag,
  output logic             Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t             state;
  logic [W-1:0]       op_in1;
  logic [W-1:0]       op_in2;
  logic [TAG_W-1:0]   op_tag;
  logic               op_src;
  logic               tr_en_q;
  logic               busy_q;
  logic               r_valid_q;
  logic [W-1:0]       r_data_q;
  logic               r_src_q;
  logic [TAG_W-1:0]   r_tag_q;
  logic               idle;
  logic               grant_a;
  logic               grant_b;
`ifndef TRUNC_SCHED_FIXED_PRIO_EN
  // Source of the most recent grant: 1 = B, so A wins the first conflict after reset.
  logic               rr_last;
`endif

  // Ready is combinational in IDLE; masking with Rst keeps it low during a reset cycle.
  always_comb begin
    idle    = (state == IDLE) && !Rst;
`ifdef TRUNC_SCHED_FIXED_PRIO_EN
    grant_a = idle && A_Valid;
`else
    grant_a = idle && A_Valid && (!B_Valid || rr_last);
`endif
    grant_b = idle && B_Valid && !grant_a;
  end

  assign A_Ready   = grant_a;
  assign B_Ready   = grant_b;
  assign Tr_In1    = op_in1;
  assign Tr_In2    = op_in2;
  assign Tr_Enable = tr_en_q;
  assign R_Valid   = r_valid_q;
  assign R_Data    = r_data_q;
  assign R_Src     = r_src_q;
  assign R_Tag     = r_tag_q;
  assign Busy      = busy_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      op_in1    <= '0;
      op_in2    <= '0;
      op_tag    <= '0;
      op_src    <= 1'b0;
      tr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_src_q   <= 1'b0;
      r_tag_q   <= '0;
`ifndef TRUNC_SCHED_FIXED_PRIO_EN
      rr_last   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            op_in1  <= grant_b ? B_In1 : A_In1;
            op_in2  <= grant_b ? B_In2 : A_In2;
            op_tag  <= grant_b ? B_Tag : A_Tag;
            op_src  <= grant_b;
`ifndef TRUNC_SCHED_FIXED_PRIO_EN
            rr_last <= grant_b;
`endif
            // Enable and Busy are registered so they line up exactly with ISSUE.
            tr_en_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          // The unit is combinational: its output is valid during this cycle.
          r_data_q  <= Tr_Out;
          r_src_q   <= op_src;
          r_tag_q   <= op_tag;
          r_valid_q <= 1'b1;
          tr_en_q   <= 1'b0;
          state     <= HOLD;
        end
        HOLD: begin
          // No accept on the handshake cycle; the next grant is evaluated in IDLE.
          if (R_Ready) begin
            r_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          tr_en_q   <= 1'b0;
          busy_q    <= 1'b0;
          r_valid_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trunc_unit_scheduler.sv
module tb_trunc_unit_scheduler;
  localparam int W     = 32;
  localparam int TAG_W = 4;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             A_Valid, A_Ready, B_Valid, B_Ready;
  logic [W-1:0]     A_In1, A_In2, B_In1, B_In2;
  logic [TAG_W-1:0] A_Tag, B_Tag;
  logic [W-1:0]     Tr_In1, Tr_In2, Tr_Out;
  logic             Tr_Enable;
  logic             R_Valid, R_Ready, R_Src, Busy;
  logic [W-1:0]     R_Data;
  logic [TAG_W-1:0] R_Tag;

  int vectors = 0;
  int errors  = 0;
  bit model_last_b;   // reference arbiter memory: last granted source was B

  always #5 Clk = ~Clk;

  // Behavioural truncation unit: bit 31 selects right shift, bits 4:0 the amount.
  function automatic logic [W-1:0] trunc_model(input logic [W-1:0] d, input logic [W-1:0] c);
    return c[31] ? (d >> c[4:0]) : (d << c[4:0]);
  endfunction

  // Garbage when not enabled, so a capture outside ISSUE is visible.
  assign Tr_Out = Tr_Enable ? trunc_model(Tr_In1, Tr_In2) : 32'hDEAD_BEEF;

  // Reference arbitration: which source should win given the current valids.
  function automatic bit expect_b(input bit av, input bit bv, input bit last_b);
`ifdef TRUNC_SCHED_FIXED_PRIO_EN
    return !av && bv;
`else
    return (av && bv) ? !last_b : (!av && bv);
`endif
  endfunction

  trunc_unit_scheduler #(.W(W), .TAG_W(TAG_W)) dut (
    .Clk(Clk), .Rst(Rst),
    .A_Valid(A_Valid), .A_Ready(A_Ready), .A_In1(A_In1), .A_In2(A_In2), .A_Tag(A_Tag),
    .B_Valid(B_Valid), .B_Ready(B_Ready), .B_In1(B_In1), .B_In2(B_In2), .B_Tag(B_Tag),
    .Tr_In1(Tr_In1), .Tr_In2(Tr_In2), .Tr_Enable(Tr_Enable), .Tr_Out(Tr_Out),
    .R_Valid(R_Valid), .R_Ready(R_Ready), .R_Data(R_Data), .R_Src(R_Src), .R_Tag(R_Tag),
    .Busy(Busy)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Rst = 1'b1; A_Valid = 1'b1; B_Valid = 1'b1; R_Ready = 1'b0;
    A_In1 = '1; A_In2 = '1; A_Tag = '1; B_In1 = '1; B_In2 = '1; B_Tag = '1;
    tick; tick;
    vectors++;
    if ({A_Ready, B_Ready, R_Valid, Tr_Enable, Busy, R_Src} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {A_Ready, B_Ready, R_Valid, Tr_Enable, Busy, R_Src});
    end
    vectors++;
    if (R_Data !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", R_Data); end
    vectors++;
    if (R_Tag !== 4'h0) begin errors++; $display("FAIL reset_rtag got %h want 0", R_Tag); end
    vectors++;
    if ({Tr_In1, Tr_In2} !== 64'h0) begin errors++; $display("FAIL reset_trin got %h want 0", {Tr_In1, Tr_In2}); end
    A_Valid = 1'b0; B_Valid = 1'b0; Rst = 1'b0;
    model_last_b = 1'b1;
    #1;
  endtask

  task automatic test_single_a;
    logic [W-1:0] exp_d;
    A_Valid = 1'b1; A_In1 = 32'hF0F0_1234; A_In2 = 32'h8000_0004; A_Tag = 4'd3;
    exp_d = trunc_model(A_In1, A_In2);
    #1;
    vectors++;
    if ({A_Ready, B_Ready} !== 2'b10) begin errors++; $display("FAIL single_a_grant got %b want 10", {A_Ready, B_Ready}); end
    tick;
    A_Valid = 1'b0;
    #1;
    vectors++;
    if ({A_Ready, Tr_Enable, Busy, R_Valid} !== 4'b0110) begin
      errors++; $display("FAIL single_a_issue got %b want 0110", {A_Ready, Tr_Enable, Busy, R_Valid});
    end
    vectors++;
    if ({Tr_In1, Tr_In2} !== {32'hF0F0_1234, 32'h8000_0004}) begin
      errors++; $display("FAIL single_a_trin got %h want f0f01234_80000004", {Tr_In1, Tr_In2});
    end
    tick;
    vectors++;
    if ({R_Valid, Tr_Enable} !== 2'b10) begin errors++; $display("FAIL single_a_rvalid got %b want 10", {R_Valid, Tr_Enable}); end
    vectors++;
    if ({R_Data, R_Src, R_Tag} !== {exp_d, 1'b0, 4'd3}) begin
      errors++; $display("FAIL single_a_result got %h/%b/%h want %h/0/3", R_Data, R_Src, R_Tag, exp_d);
    end
    R_Ready = 1'b1;
    tick;
    R_Ready = 1'b0;
    vectors++;
    if ({R_Valid, Busy} !== 2'b00) begin errors++; $display("FAIL single_a_done got %b want 00", {R_Valid, Busy}); end
    model_last_b = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [W-1:0] exp_d;
    bit eb;
    Rst = 1'b1; tick; Rst = 1'b0; model_last_b = 1'b1;
    A_Valid = 1'b1; B_Valid = 1'b1; R_Ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      A_In1 = $urandom; A_In2 = $urandom; A_Tag = 4'(t);
      B_In1 = $urandom; B_In2 = $urandom; B_Tag = 4'(t + 8);
      #1;
      for (int k = 0; k < 10 && !(A_Ready || B_Ready); k++) tick;
      eb = expect_b(1'b1, 1'b1, model_last_b);
      vectors++;
      if ({A_Ready, B_Ready} !== {!eb, eb}) begin
        errors++; $display("FAIL rr_grant%0d got %b want %b", t, {A_Ready, B_Ready}, {!eb, eb});
      end
      exp_d = eb ? trunc_model(B_In1, B_In2) : trunc_model(A_In1, A_In2);
      model_last_b = eb;
      tick; tick;
      vectors++;
      if ({R_Valid, R_Src, R_Data} !== {1'b1, eb, exp_d}) begin
        errors++; $display("FAIL rr_result%0d got %b/%b/%h want 1/%b/%h", t, R_Valid, R_Src, R_Data, eb, exp_d);
      end
      tick;
    end
    A_Valid = 1'b0; B_Valid = 1'b0; R_Ready = 1'b0;
    #1;
  endtask

  task automatic test_hold_stall;
    logic [W-1:0] exp_d, exp_b_d;
    logic [TAG_W-1:0] exp_t;
    A_Valid = 1'b1; A_In1 = $urandom; A_In2 = $urandom; A_Tag = 4'(9);
    exp_d = trunc_model(A_In1, A_In2); exp_t = A_Tag;
    R_Ready = 1'b0;
    #1;
    vectors++;
    if (A_Ready !== 1'b1) begin errors++; $display("FAIL stall_grant got %b want 1", A_Ready); end
    tick;
    A_Valid = 1'b0;
    B_Valid = 1'b1; B_In1 = $urandom; B_In2 = $urandom; B_Tag = 4'd5;
    exp_b_d = trunc_model(B_In1, B_In2);
    tick;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({R_Valid, R_Data, R_Tag} !== {1'b1, exp_d, exp_t}) begin
        errors++; $display("FAIL stall_hold%0d got %b/%h/%h want 1/%h/%h", i, R_Valid, R_Data, R_Tag, exp_d, exp_t);
      end
      vectors++;
      if ({A_Ready, B_Ready, Tr_Enable} !== 3'b000) begin
        errors++; $display("FAIL stall_quiet%0d got %b want 000", i, {A_Ready, B_Ready, Tr_Enable});
      end
      tick;
    end
    R_Ready = 1'b1;
    tick;
    R_Ready = 1'b0;
    #1;
    vectors++;
    if ({R_Valid, A_Ready, B_Ready} !== 3'b001) begin
      errors++; $display("FAIL stall_next_grant got %b want 001", {R_Valid, A_Ready, B_Ready});
    end
    model_last_b = 1'b1;
    tick;
    B_Valid = 1'b0;
    tick;
    vectors++;
    if ({R_Valid, R_Src, R_Tag, R_Data} !== {1'b1, 1'b1, 4'd5, exp_b_d}) begin
      errors++; $display("FAIL stall_b_result got %b/%b/%h/%h want 1/1/5/%h", R_Valid, R_Src, R_Tag, R_Data, exp_b_d);
    end
    R_Ready = 1'b1; tick; R_Ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    A_Valid = 1'b1; A_In1 = $urandom; A_In2 = $urandom; A_Tag = 4'd1;
    tick;
    A_Valid = 1'b0;
    #1;
    vectors++;
    if (Tr_Enable !== 1'b1) begin errors++; $display("FAIL rstmid_issue got %b want 1", Tr_Enable); end
    Rst = 1'b1;
    tick;
    vectors++;
    if ({Busy, R_Valid, Tr_Enable} !== 3'b000) begin
      errors++; $display("FAIL rstmid_cleared got %b want 000", {Busy, R_Valid, Tr_Enable});
    end
    Rst = 1'b0; model_last_b = 1'b1;
    A_Valid = 1'b1; B_Valid = 1'b1; A_Tag = 4'd2; B_Tag = 4'd6;
    #1;
    vectors++;
    if ({A_Ready, B_Ready} !== 2'b10) begin errors++; $display("FAIL rstmid_prio got %b want 10", {A_Ready, B_Ready}); end
    tick;
    A_Valid = 1'b0; B_Valid = 1'b0;
    tick;
    vectors++;
    if ({R_Valid, R_Src, R_Tag} !== {1'b1, 1'b0, 4'd2}) begin
      errors++; $display("FAIL rstmid_result got %b/%b/%h want 1/0/2", R_Valid, R_Src, R_Tag);
    end
    R_Ready = 1'b1; tick; R_Ready = 1'b0;
    model_last_b = 1'b0;
  endtask

  task automatic test_only_b;
    logic [W-1:0] exp_d;
    B_Valid = 1'b1; B_In1 = $urandom; B_In2 = 32'h0000_001F; B_Tag = 4'd15;
    exp_d = trunc_model(B_In1, B_In2);
    #1;
    vectors++;
    if ({A_Ready, B_Ready} !== 2'b01) begin errors++; $display("FAIL only_b_grant got %b want 01", {A_Ready, B_Ready}); end
    tick;
    B_Valid = 1'b0;
    tick;
    vectors++;
    if ({R_Valid, R_Src, R_Tag, R_Data} !== {1'b1, 1'b1, 4'd15, exp_d}) begin
      errors++; $display("FAIL only_b_result got %b/%b/%h/%h want 1/1/f/%h", R_Valid, R_Src, R_Tag, R_Data, exp_d);
    end
    R_Ready = 1'b1; tick; R_Ready = 1'b0;
    model_last_b = 1'b1;
  endtask

  task automatic test_drop_valid;
    A_Valid = 1'b1; A_In1 = $urandom; A_In2 = $urandom; A_Tag = 4'd4;
    tick;
    A_Valid = 1'b0;
    tick;
    B_Valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (B_Ready !== 1'b0) begin errors++; $display("FAIL drop_hold_ready%0d got %b want 0", i, B_Ready); end
      tick;
    end
    B_Valid = 1'b0; R_Ready = 1'b1;
    tick;
    R_Ready = 1'b0;
    #1;
    vectors++;
    if ({A_Ready, B_Ready, Busy, R_Valid} !== 4'b0000) begin
      errors++; $display("FAIL drop_idle got %b want 0000", {A_Ready, B_Ready, Busy, R_Valid});
    end
    tick;
    vectors++;
    if ({Busy, Tr_Enable} !== 2'b00) begin errors++; $display("FAIL drop_no_accept got %b want 00", {Busy, Tr_Enable}); end
    model_last_b = 1'b0;
  endtask

  task automatic test_random;
    logic [W-1:0]     q_data[$];
    bit               q_src[$];
    logic [TAG_W-1:0] q_tag[$];
    bit issue_exp, acc_a, acc_b, r_hs, eb, idle_exp;
    Rst = 1'b1; tick; Rst = 1'b0; model_last_b = 1'b1; issue_exp = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!A_Valid && cyc < 360 && $urandom_range(0, 2) != 0) begin
        A_Valid = 1'b1; A_In1 = $urandom; A_In2 = $urandom; A_Tag = 4'($urandom);
      end
      if (!B_Valid && cyc < 360 && $urandom_range(0, 2) != 0) begin
        B_Valid = 1'b1; B_In1 = $urandom; B_In2 = $urandom; B_Tag = 4'($urandom);
      end
      R_Ready = (cyc >= 360) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      idle_exp = (q_data.size() == 0);
      vectors++;
      if (Tr_Enable !== issue_exp) begin
        errors++; $display("FAIL rand_enable cyc %0d got %b want %b", cyc, Tr_Enable, issue_exp);
      end
      eb = expect_b(A_Valid, B_Valid, model_last_b);
      vectors++;
      if (idle_exp && (A_Valid || B_Valid)) begin
        if ({A_Ready, B_Ready} !== {!eb, eb}) begin
          errors++; $display("FAIL rand_grant cyc %0d got %b want %b", cyc, {A_Ready, B_Ready}, {!eb, eb});
        end
      end else if ({A_Ready, B_Ready} !== 2'b00) begin
        errors++; $display("FAIL rand_noready cyc %0d got %b want 00", cyc, {A_Ready, B_Ready});
      end
      vectors++;
      if (R_Valid !== (!idle_exp && !issue_exp)) begin
        errors++; $display("FAIL rand_rvalid cyc %0d got %b want %b", cyc, R_Valid, !idle_exp && !issue_exp);
      end
      if (R_Valid === 1'b1 && q_data.size() != 0) begin
        vectors++;
        if ({R_Src, R_Tag, R_Data} !== {q_src[0], q_tag[0], q_data[0]}) begin
          errors++; $display("FAIL rand_result cyc %0d got %b/%h/%h want %b/%h/%h",
                             cyc, R_Src, R_Tag, R_Data, q_src[0], q_tag[0], q_data[0]);
        end
      end
      acc_a = A_Valid && A_Ready;
      acc_b = B_Valid && B_Ready;
      r_hs  = R_Valid && R_Ready;
      tick;
      issue_exp = acc_a || acc_b;
      if (acc_a) begin
        q_data.push_back(trunc_model(A_In1, A_In2)); q_src.push_back(1'b0); q_tag.push_back(A_Tag);
        A_Valid = 1'b0; model_last_b = 1'b0;
      end
      if (acc_b) begin
        q_data.push_back(trunc_model(B_In1, B_In2)); q_src.push_back(1'b1); q_tag.push_back(B_Tag);
        B_Valid = 1'b0; model_last_b = 1'b1;
      end
      if (r_hs && q_data.size() != 0) begin
        void'(q_data.pop_front()); void'(q_src.pop_front()); void'(q_tag.pop_front());
      end
    end
    vectors++;
    if (q_data.size() != 0 || A_Valid || B_Valid) begin
      errors++; $display("FAIL rand_drain got %0d pending results, valids %b want 0/00", q_data.size(), {A_Valid, B_Valid});
    end
    R_Ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_round_robin();
    test_hold_stall();
    test_reset_mid();
    test_only_b();
    test_drop_valid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/trunc_unit_scheduler.md
Name: trunc_unit_scheduler

Overview:
- Shares one combinational 32-bit truncation unit between two requesters (port A, port B) in the ALU32 gate-level datapath.
- Arbitrates requests round-robin, drives the unit's In1/In2/Enable, registers the unit's Out, and returns the result to the granted requester with a valid/ready handshake.
- Sits between the ALU op decoder / shift-sequencing logic and the truncation unit instance.

Parameters:
- W, 32, data width of operand, control word and result; fixed at 32 for ALU32 use.
- TAG_W, 4, width of the requester-supplied transaction tag echoed with the result.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  reset, synchronous, active-high.
- A_Valid  input  1  requester A has a request.
- A_Ready  output  1  A request accepted this cycle.
- A_In1  input  W  A data operand.
- A_In2  input  W  A control word: bit 31 = direction, bits 4:0 = amount.
- A_Tag  input  TAG_W  A transaction tag.
- B_Valid, B_Ready, B_In1, B_In2, B_Tag  same as A, for requester B.
- Tr_In1  output  W  to truncation unit In1.
- Tr_In2  output  W  to truncation unit In2.
- Tr_Enable  output  1  to truncation unit Enable.
- Tr_Out  input  W  from truncation unit Out; combinational in the same cycle.
- R_Valid  output  1  result valid.
- R_Ready  input  1  consumer accepts the result.
- R_Data  output  W  registered result.
- R_Src  output  1  source of the result: 0 = A, 1 = B.
- R_Tag  output  TAG_W  tag of the result.
- Busy  output  1  FSM not in IDLE.

Behaviour:
- Reset values (Rst high at a clock edge):
  - State = IDLE; rr_last = 1, so A has priority first.
  - A_Ready = B_Ready = 0; R_Valid = 0.
  - R_Data = 0, R_Src = 0, R_Tag = 0.
  - Tr_Enable = 0; Tr_In1 = Tr_In2 = 0; Busy = 0.
- States: IDLE, ISSUE, HOLD.
- IDLE:
  - If A_Valid or B_Valid is high, grant one requester and pulse its X_Ready for 1 cycle (combinational in IDLE).
  - Latch In1, In2, Tag and the source into op registers; go to ISSUE.
  - A request is accepted only on a cycle where X_Valid && X_Ready.
- Arbitration:
  - If only one requester is valid, it is granted.
  - If both are valid, grant the requester that is not rr_last.
  - rr_last updates to the granted source at acceptance.
- ISSUE (exactly 1 cycle):
  - Tr_In1/Tr_In2 = op registers; Tr_Enable = 1.
  - At the clock edge, capture Tr_Out into R_Data, copy source/tag into R_Src/R_Tag, set R_Valid = 1, go to HOLD.
- HOLD:
  - Tr_Enable = 0; Tr_In1/Tr_In2 hold the op registers.
  - R_Data, R_Src and R_Tag are stable while R_Valid && !R_Ready.
  - On R_Valid && R_Ready: clear R_Valid and go to IDLE. No accept in the same cycle, so throughput is 1 op per 3 cycles minimum.
- Latency: acceptance edge to R_Valid = 2 clock edges.
- Tr_Enable is high only in ISSUE; it is never high in IDLE or HOLD.
- X_Ready is 0 in ISSUE and HOLD. Valid requests in those states wait; requesters must hold Valid and data until Ready.
- Operands pass through unmodified; no width conversion, sign handling or interpretation of In2 beyond transport.
- Rst asserted mid-operation (ISSUE or HOLD): the operation is abandoned, no result is produced, all reset values apply next cycle, and rr_last returns to 1.
- Back-to-back: B valid continuously while A completes → B is granted on the first IDLE cycle after the A handshake.

Optional Feature:
- Macro: TRUNC_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, A always wins when both are valid; rr_last is not implemented.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Reset, then A_Valid=1, A_In1=32'hF0F0_1234, A_In2=32'h8000_0004, A_Tag=3:
  - A_Ready pulses 1 cycle.
  - Tr_Enable=1 for exactly 1 cycle with Tr_In2=32'h8000_0004.
  - R_Valid rises 2 edges after acceptance, with R_Data=Tr_Out, R_Src=0, R_Tag=3.
- A and B valid together from reset:
  - Grants in order A, B, A, B over 4 transactions.
  - With TRUNC_SCHED_FIXED_PRIO_EN defined: A, A, A, A while A stays valid.
- R_Ready held 0 for 5 cycles in HOLD:
  - R_Valid, R_Data and R_Tag are stable.
  - A_Ready/B_Ready stay 0 and Tr_Enable stays 0.
  - Raising R_Ready completes the op; the next grant follows 1 cycle later.
- Rst pulsed in ISSUE:
  - Next cycle Busy=0, R_Valid=0, Tr_Enable=0.
  - A subsequent A+B conflict grants A first.
- Only B valid, B_In2=32'h0000_001F, B_Tag=15:
  - Granted immediately.
  - Result has R_Src=1, R_Tag=15, R_Data=Tr_Out sampled in ISSUE.
- Requester drops Valid while not ready (in HOLD): no request is accepted, and no spurious Ready pulse occurs on return to IDLE.
